// File: rtl/rv_soc_ahb2apb_8b_bridge_if.sv
// AHB3-Lite slave / 8-bit APB master signal bundle for the ahb2apb bridge.
// Modport slave is the bridge's view; modport master is the surrounding system's view.
interface rv_soc_ahb2apb_8b_bridge_if #(
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32,
  parameter int PADDR_SIZE = 16,
  parameter int PDATA_SIZE = 8
);
  logic                  HSEL;
  logic [HADDR_SIZE-1:0] HADDR;
  logic [HDATA_SIZE-1:0] HWDATA;
  logic [HDATA_SIZE-1:0] HRDATA;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [2:0]            HBURST;
  logic [3:0]            HPROT;
  logic [1:0]            HTRANS;
  logic                  HMASTLOCK;
  logic                  HREADY;
  logic                  HREADYOUT;
  logic                  HRESP;

  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [2:0]            PPROT;
  logic                  PSTRB;
  logic [PADDR_SIZE-1:0] PADDR;
  logic [PDATA_SIZE-1:0] PWDATA;
  logic [PDATA_SIZE-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport slave (
    input  HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HREADY,
    output HRDATA, HREADYOUT, HRESP,
    output PSEL, PENABLE, PWRITE, PPROT, PSTRB, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport master (
    output HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HREADY,
    input  HRDATA, HREADYOUT, HRESP,
    input  PSEL, PENABLE, PWRITE, PPROT, PSTRB, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/rv_soc_ahb2apb_8b_bridge.sv
// AHB3-Lite to 8-bit APB bridge: splits byte/half/word accesses into 1/2/4 little-endian APB beats.
// Latency LOAD + 2 cycles per beat (+1 per PREADY=0 cycle); AHB stalled via HREADYOUT, PSLVERR -> 2-cycle ERROR.
module rv_soc_ahb2apb_8b_bridge #(
  parameter int HADDR_SIZE = 32,
  parameter int PADDR_SIZE = 16
) (
  input  logic                     HCLK,
  input  logic                     HRESETn,
  rv_soc_ahb2apb_8b_bridge_if.slave bus
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_SETUP  = 3'd2;
  localparam logic [2:0] ST_ACCESS = 3'd3;
  localparam logic [2:0] ST_ERR1   = 3'd4;
  localparam logic [2:0] ST_ERR2   = 3'd5;

  logic [2:0]            state_q, state_d;
  logic [PADDR_SIZE-1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic [1:0]            size_q, size_d;
  logic [2:0]            pprot_q, pprot_d;
  logic [1:0]            beat_q, beat_d;
  logic [31:0]           wbuf_q, wbuf_d;
  logic [31:0]           rbuf_q, rbuf_d;
  logic [31:0]           rdata_q, rdata_d;

  logic        accept;
  logic        reject;
  logic        last_beat;
  logic [1:0]  lane;
  logic [31:0] rmerge;
  logic        unused_ok;

  assign accept = bus.HSEL & bus.HREADY & bus.HTRANS[1];
  assign reject = (bus.HSIZE > 3'd2)
               || ((bus.HSIZE == 3'd1) && bus.HADDR[0])
               || ((bus.HSIZE == 3'd2) && (bus.HADDR[1:0] != 2'b00));

  // Alignment is enforced on accept, so lane never wraps past the word.
  assign lane      = addr_q[1:0] + beat_q;
  assign last_beat = (beat_q == {size_q[1], size_q[1] | size_q[0]});

  // Beat 0 starts from zero so lanes outside the access read back as 0.
  always_comb begin
    rmerge = (beat_q == 2'd0) ? 32'd0 : rbuf_q;
    rmerge[{lane, 3'b000} +: 8] = bus.PRDATA;
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    write_d = write_q;
    size_d  = size_q;
    pprot_d = pprot_q;
    beat_d  = beat_q;
    wbuf_d  = wbuf_q;
    rbuf_d  = rbuf_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE, ST_ERR2: begin
        state_d = ST_IDLE;
        if (accept) begin
          addr_d  = bus.HADDR[PADDR_SIZE-1:0];
          write_d = bus.HWRITE;
          size_d  = bus.HSIZE[1:0];
          pprot_d = {~bus.HPROT[0], 1'b1, bus.HPROT[1]};
          beat_d  = 2'd0;
          state_d = reject ? ST_ERR1 : ST_LOAD;
        end
      end
      ST_LOAD: begin
        wbuf_d  = bus.HWDATA;
        state_d = ST_SETUP;
      end
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (bus.PREADY) begin
          if (bus.PSLVERR) begin
            state_d = ST_ERR1;
          end else begin
            if (!write_q) begin
              rbuf_d = rmerge;
              if (last_beat) rdata_d = rmerge;
            end
            if (last_beat) begin
              state_d = ST_IDLE;
            end else begin
              beat_d  = beat_q + 2'd1;
              state_d = ST_SETUP;
            end
          end
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= 2'd0;
      pprot_q <= 3'd0;
      beat_q  <= 2'd0;
      wbuf_q  <= 32'd0;
      rbuf_q  <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      size_q  <= size_d;
      pprot_q <= pprot_d;
      beat_q  <= beat_d;
      wbuf_q  <= wbuf_d;
      rbuf_q  <= rbuf_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.HREADYOUT = (state_q == ST_IDLE) || (state_q == ST_ERR2);
  assign bus.HRESP     = (state_q == ST_ERR1) || (state_q == ST_ERR2);
  assign bus.HRDATA    = rdata_q;

  assign bus.PSEL    = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign bus.PENABLE = (state_q == ST_ACCESS);
  assign bus.PWRITE  = write_q;
  assign bus.PSTRB   = write_q;
  assign bus.PPROT   = pprot_q;
  assign bus.PADDR   = addr_q + PADDR_SIZE'(beat_q);
  assign bus.PWDATA  = wbuf_q[{lane, 3'b000} +: 8];

  assign unused_ok = ^{bus.HBURST, bus.HMASTLOCK, bus.HPROT[3:2], bus.HTRANS[0],
                       bus.HADDR[HADDR_SIZE-1:PADDR_SIZE]};

endmodule

// File: tb/tb_rv_soc_ahb2apb_8b_bridge.sv
// Directed bench for the AHB-to-8-bit-APB bridge: vector table plus multi-cycle corner sequences.
module tb_rv_soc_ahb2apb_8b_bridge;

  logic HCLK = 1'b0;
  logic HRESETn;
  always #5 HCLK = ~HCLK;

  rv_soc_ahb2apb_8b_bridge_if bus ();
  assign bus.HREADY = bus.HREADYOUT;

  rv_soc_ahb2apb_8b_bridge dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // APB slave model controls, written by the stimulus process only
  int          stall_at  = -1;
  int          stall_req = 0;
  int          err_at    = -1;
  logic [31:0] rdpat     = 32'd0;

  // APB slave model state, owned by the monitor process
  int          apb_n    = 0;
  int          wait_cnt = 0;
  int          stab_err = 0;
  logic [15:0] su_pa;
  logic [7:0]  su_pw;
  logic        su_wr;
  logic [15:0] log_pa [256];
  logic [7:0]  log_pw [256];
  logic        log_wr [256];
  logic        log_st [256];
  logic [2:0]  log_pp [256];

  always @(negedge HCLK) begin
    if (bus.PSEL && bus.PENABLE) begin
      if (bus.PADDR !== su_pa || bus.PWDATA !== su_pw || bus.PWRITE !== su_wr) stab_err++;
      if (apb_n == stall_at && wait_cnt < stall_req) begin
        bus.PREADY = 1'b0;
        wait_cnt++;
      end else begin
        bus.PREADY  = 1'b1;
        wait_cnt    = 0;
        bus.PSLVERR = (apb_n == err_at);
        bus.PRDATA  = rdpat[{bus.PADDR[1:0], 3'b000} +: 8];
        if (apb_n < 256) begin
          log_pa[apb_n[7:0]] = bus.PADDR;
          log_pw[apb_n[7:0]] = bus.PWDATA;
          log_wr[apb_n[7:0]] = bus.PWRITE;
          log_st[apb_n[7:0]] = bus.PSTRB;
          log_pp[apb_n[7:0]] = bus.PPROT;
        end
        apb_n++;
      end
    end else begin
      bus.PREADY  = 1'b1;
      bus.PSLVERR = 1'b0;
      bus.PRDATA  = 8'h00;
      if (bus.PSEL) begin
        su_pa = bus.PADDR;
        su_pw = bus.PWDATA;
        su_wr = bus.PWRITE;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_ready(output int waits, output logic r0, output logic rprev);
    waits = 0;
    rprev = 1'b0;
    @(negedge HCLK);
    r0 = bus.HRESP;
    while (!bus.HREADYOUT && waits < 200) begin
      rprev = bus.HRESP;
      waits++;
      @(negedge HCLK);
    end
  endtask

  task automatic addr_phase(input logic [2:0] sz, input logic [31:0] addr, input logic wr,
                            input logic [3:0] hp);
    bus.HSEL   = 1'b1;
    bus.HTRANS = 2'b10;
    bus.HADDR  = addr;
    bus.HSIZE  = sz;
    bus.HWRITE = wr;
    bus.HPROT  = hp;
  endtask

  task automatic bus_idle();
    bus.HSEL   = 1'b0;
    bus.HTRANS = 2'b00;
  endtask

  task automatic do_xfer(input logic [2:0] sz, input logic [31:0] addr, input logic wr,
                         input logic [31:0] wd, input logic [3:0] hp,
                         output int waits, output logic r0, output logic rprev,
                         output logic rl, output logic [31:0] rd);
    @(posedge HCLK); #1;
    addr_phase(sz, addr, wr, hp);
    @(posedge HCLK); #1;
    bus_idle();
    bus.HWDATA = wd;
    wait_ready(waits, r0, rprev);
    rl = bus.HRESP;
    rd = bus.HRDATA;
  endtask

  typedef struct {
    logic [2:0]  sz;
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wd;
    logic [31:0] rdpat;
    logic [3:0]  hprot;
    int          waits;
    logic        resp;
    int          napb;
    logic [15:0] pa0;
    logic [15:0] pal;
    logic [7:0]  pw0;
    logic [7:0]  pwl;
    logic [2:0]  pprot;
    logic [31:0] rd;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  initial begin
    int          w, base, n, idx, found;
    logic        r0, rp, rl;
    logic [31:0] rd;

    vecs[0] = '{3'd0, 32'h0000_0103, 1'b1, 32'hA500_0000, 32'h0,         4'h3, 3, 1'b0, 1, 16'h0103, 16'h0103, 8'hA5, 8'hA5, 3'b011, 32'h0};
    vecs[1] = '{3'd2, 32'h0000_0200, 1'b0, 32'h0,         32'h4433_2211, 4'h1, 9, 1'b0, 4, 16'h0200, 16'h0203, 8'h00, 8'h00, 3'b010, 32'h4433_2211};
    vecs[2] = '{3'd1, 32'h0000_0306, 1'b0, 32'h0,         32'hCAFE_1234, 4'h2, 5, 1'b0, 2, 16'h0306, 16'h0307, 8'h00, 8'h00, 3'b111, 32'hCAFE_0000};
    vecs[3] = '{3'd0, 32'h0000_0401, 1'b0, 32'h0,         32'hAABB_77CC, 4'h0, 3, 1'b0, 1, 16'h0401, 16'h0401, 8'h00, 8'h00, 3'b110, 32'h0000_7700};
    vecs[4] = '{3'd0, 32'h1234_0002, 1'b1, 32'h00C3_0000, 32'h0,         4'h1, 3, 1'b0, 1, 16'h0002, 16'h0002, 8'hC3, 8'hC3, 3'b010, 32'h0000_7700};
    vecs[5] = '{3'd2, 32'h0000_0020, 1'b1, 32'hDDCC_BBAA, 32'h0,         4'h1, 9, 1'b0, 4, 16'h0020, 16'h0023, 8'hAA, 8'hDD, 3'b010, 32'h0000_7700};
    vecs[6] = '{3'd2, 32'h0000_0002, 1'b0, 32'h0,         32'h0,         4'h1, 1, 1'b1, 0, 16'h0,    16'h0,    8'h00, 8'h00, 3'b000, 32'h0000_7700};
    vecs[7] = '{3'd3, 32'h0000_0000, 1'b0, 32'h0,         32'h0,         4'h1, 1, 1'b1, 0, 16'h0,    16'h0,    8'h00, 8'h00, 3'b000, 32'h0000_7700};
    vecs[8] = '{3'd1, 32'h0000_0001, 1'b1, 32'h0,         32'h0,         4'h1, 1, 1'b1, 0, 16'h0,    16'h0,    8'h00, 8'h00, 3'b000, 32'h0000_7700};
    vecs[9] = '{3'd0, 32'h0000_0000, 1'b0, 32'h0,         32'h1234_565A, 4'h1, 3, 1'b0, 1, 16'h0000, 16'h0000, 8'h00, 8'h00, 3'b010, 32'h0000_005A};

    HRESETn       = 1'b0;
    bus.HSEL      = 1'b0;
    bus.HTRANS    = 2'b00;
    bus.HADDR     = 32'd0;
    bus.HSIZE     = 3'd0;
    bus.HWRITE    = 1'b0;
    bus.HWDATA    = 32'd0;
    bus.HBURST    = 3'd0;
    bus.HPROT     = 4'd0;
    bus.HMASTLOCK = 1'b0;

    repeat (3) @(negedge HCLK);
    chk("rst_hreadyout", 32'(bus.HREADYOUT), 32'd1);
    chk("rst_hresp",     32'(bus.HRESP),     32'd0);
    chk("rst_hrdata",    bus.HRDATA,         32'd0);
    chk("rst_psel",      32'(bus.PSEL),      32'd0);
    chk("rst_penable",   32'(bus.PENABLE),   32'd0);
    chk("rst_pwrite",    32'(bus.PWRITE),    32'd0);
    chk("rst_pstrb",     32'(bus.PSTRB),     32'd0);
    chk("rst_paddr",     32'(bus.PADDR),     32'd0);
    chk("rst_pwdata",    32'(bus.PWDATA),    32'd0);
    chk("rst_pprot",     32'(bus.PPROT),     32'd0);
    HRESETn = 1'b1;

    // IDLE transfer and unselected NONSEQ both get zero-wait OKAY
    @(posedge HCLK); #1;
    bus.HSEL = 1'b1; bus.HTRANS = 2'b00; bus.HADDR = 32'h100;
    @(posedge HCLK); #1;
    bus.HSEL = 1'b0; bus.HTRANS = 2'b10;
    @(negedge HCLK);
    chk("idle_hreadyout", 32'(bus.HREADYOUT), 32'd1);
    chk("idle_hresp",     32'(bus.HRESP),     32'd0);
    @(posedge HCLK); #1;
    bus_idle();
    @(negedge HCLK);
    chk("nosel_hreadyout", 32'(bus.HREADYOUT), 32'd1);
    chk("nosel_psel",      32'(bus.PSEL),      32'd0);

    for (int v = 0; v < NV; v++) begin
      base  = apb_n;
      rdpat = vecs[v].rdpat;
      do_xfer(vecs[v].sz, vecs[v].addr, vecs[v].wr, vecs[v].wd, vecs[v].hprot, w, r0, rp, rl, rd);
      n = apb_n - base;
      chk($sformatf("v%0d_waits", v),     32'(w),  32'(vecs[v].waits));
      chk($sformatf("v%0d_resp_first", v), 32'(r0), 32'(vecs[v].resp));
      chk($sformatf("v%0d_resp_last", v),  32'(rl), 32'(vecs[v].resp));
      chk($sformatf("v%0d_napb", v),       32'(n),  32'(vecs[v].napb));
      chk($sformatf("v%0d_hrdata", v),     rd,      vecs[v].rd);
      if (vecs[v].napb > 0 && n > 0) begin
        idx = base + n - 1;
        chk($sformatf("v%0d_paddr0", v),  32'(log_pa[base[7:0]]), 32'(vecs[v].pa0));
        chk($sformatf("v%0d_paddrN", v),  32'(log_pa[idx[7:0]]),  32'(vecs[v].pal));
        chk($sformatf("v%0d_pwrite0", v), 32'(log_wr[base[7:0]]), 32'(vecs[v].wr));
        chk($sformatf("v%0d_pstrb0", v),  32'(log_st[base[7:0]]), 32'(vecs[v].wr));
        chk($sformatf("v%0d_pprot0", v),  32'(log_pp[base[7:0]]), 32'(vecs[v].pprot));
        if (vecs[v].wr) begin
          chk($sformatf("v%0d_pwdata0", v), 32'(log_pw[base[7:0]]), 32'(vecs[v].pw0));
          chk($sformatf("v%0d_pwdataN", v), 32'(log_pw[idx[7:0]]),  32'(vecs[v].pwl));
        end
      end
    end

    // Halfword write with two PREADY=0 cycles on beat 0
    base      = apb_n;
    stall_at  = apb_n;
    stall_req = 2;
    do_xfer(3'd1, 32'h0000_0012, 1'b1, 32'hBEEF_0000, 4'h1, w, r0, rp, rl, rd);
    stall_at  = -1;
    chk("hw_stall_waits", 32'(w), 32'd7);
    chk("hw_stall_resp",  32'(rl), 32'd0);
    chk("hw_stall_napb",  32'(apb_n - base), 32'd2);
    idx = base + 1;
    chk("hw_stall_pa0", 32'(log_pa[base[7:0]]), 32'h12);
    chk("hw_stall_pw0", 32'(log_pw[base[7:0]]), 32'hEF);
    chk("hw_stall_pa1", 32'(log_pa[idx[7:0]]),  32'h13);
    chk("hw_stall_pw1", 32'(log_pw[idx[7:0]]),  32'hBE);
    chk("hw_stall_hrdata_held", rd, 32'h0000_005A);

    // Word write, PSLVERR on beat 1: remaining beats aborted, 2-cycle ERROR
    base   = apb_n;
    err_at = apb_n + 1;
    do_xfer(3'd2, 32'h0000_0010, 1'b1, 32'h0403_0201, 4'h1, w, r0, rp, rl, rd);
    chk("slverr_waits",      32'(w),  32'd6);
    chk("slverr_resp_first", 32'(r0), 32'd0);
    chk("slverr_resp_err1",  32'(rp), 32'd1);
    chk("slverr_resp_err2",  32'(rl), 32'd1);
    chk("slverr_psel_err2",  32'(bus.PSEL), 32'd0);
    chk("slverr_napb",       32'(apb_n - base), 32'd2);
    @(negedge HCLK);
    err_at = -1;
    chk("slverr_after_resp",  32'(bus.HRESP),     32'd0);
    chk("slverr_after_ready", 32'(bus.HREADYOUT), 32'd1);

    // Byte read immediately followed by a pipelined byte write
    base  = apb_n;
    rdpat = 32'h0000_9C00;
    @(posedge HCLK); #1;
    addr_phase(3'd0, 32'h0000_0041, 1'b0, 4'h1);
    @(posedge HCLK); #1;
    addr_phase(3'd0, 32'h0000_0042, 1'b1, 4'h1);
    bus.HWDATA = 32'd0;
    wait_ready(w, r0, rp);
    chk("b2b_rd_waits",  32'(w), 32'd3);
    chk("b2b_rd_hrdata", bus.HRDATA, 32'h0000_9C00);
    @(posedge HCLK); #1;
    bus_idle();
    bus.HWDATA = 32'h005E_0000;
    wait_ready(w, r0, rp);
    idx = base + 1;
    chk("b2b_wr_waits",  32'(w), 32'd3);
    chk("b2b_napb",      32'(apb_n - base), 32'd2);
    chk("b2b_rd_pwrite", 32'(log_wr[base[7:0]]), 32'd0);
    chk("b2b_wr_paddr",  32'(log_pa[idx[7:0]]),  32'h42);
    chk("b2b_wr_pwdata", 32'(log_pw[idx[7:0]]),  32'h5E);
    chk("b2b_wr_pwrite", 32'(log_wr[idx[7:0]]),  32'd1);
    chk("b2b_hrdata_held", bus.HRDATA, 32'h0000_9C00);

    // Reset asserted during a stalled ACCESS cycle
    base      = apb_n;
    stall_at  = apb_n;
    stall_req = 6;
    @(posedge HCLK); #1;
    addr_phase(3'd2, 32'h0000_0080, 1'b1, 4'h1);
    @(posedge HCLK); #1;
    bus_idle();
    bus.HWDATA = 32'h1122_3344;
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      @(negedge HCLK);
      if (bus.PENABLE === 1'b1) found = 1;
    end
    chk("rst_mid_reached_access", 32'(found), 32'd1);
    #1 HRESETn = 1'b0;
    #1;
    chk("rst_mid_psel",      32'(bus.PSEL),      32'd0);
    chk("rst_mid_penable",   32'(bus.PENABLE),   32'd0);
    chk("rst_mid_hreadyout", 32'(bus.HREADYOUT), 32'd1);
    chk("rst_mid_hresp",     32'(bus.HRESP),     32'd0);
    chk("rst_mid_hrdata",    bus.HRDATA,         32'd0);
    chk("rst_mid_paddr",     32'(bus.PADDR),     32'd0);
    chk("rst_mid_pwrite",    32'(bus.PWRITE),    32'd0);
    chk("rst_mid_napb",      32'(apb_n - base),  32'd0);
    @(negedge HCLK);
    HRESETn  = 1'b1;
    stall_at = -1;
    rdpat    = 32'h0000_0066;
    do_xfer(3'd0, 32'h0000_0000, 1'b0, 32'd0, 4'h1, w, r0, rp, rl, rd);
    chk("post_rst_waits",  32'(w), 32'd3);
    chk("post_rst_hrdata", rd, 32'h0000_0066);

    chk("apb_stable_setup_access", 32'(stab_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
